riscv_dmem_arbiter: RTL and testbench
=====================================

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 SHALL provide parameter: RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority (port 0 wins).
REQ-002 SHALL have port: i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port: i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: i_req  input  2  per-requester access request; bit n = requester n.
REQ-005 SHALL have port: i_addr  input  2*XLEN  per-requester byte address; requester n in bits [n*XLEN +: XLEN].
REQ-006 SHALL have port: i_wr_en  input  2  per-requester write (1) / read (0).
REQ-007 SHALL have port: i_wr_data  input  2*XLEN  per-requester write data, packed as i_addr.
REQ-008 SHALL have port: i_byte_sel  input  2*XLEN/8  per-requester byte enables, packed 4 bits per requester.
REQ-009 SHALL have port: o_gnt  output  2  one-hot, request accepted by memory this cycle.
REQ-010 SHALL have port: o_rvalid  output  2  one-hot, read data valid for requester n.
REQ-011 SHALL have port: o_rd_data  output  XLEN  read data, shared, qualified by o_rvalid.
REQ-012 SHALL have port: o_mem_en  output  1  memory request valid.
REQ-013 SHALL have port: o_mem_addr / o_mem_wr_en / o_mem_wr_data / o_mem_byte_sel  output  XLEN/1/XLEN/XLEN/8  winner's fields.
REQ-014 SHALL have port: i_mem_ready  input  1  memory accepts request this cycle.
REQ-015 SHALL have port: i_mem_rvalid / i_mem_rd_data  input  1/XLEN  read response from memory.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD, RD_WAIT.
REQ-017 IDLE: any i_req set -> select winner, o_mem_en=1, memory fields driven combinationally from winner in the same cycle.
REQ-018 Winner selection: single requester wins outright; both requesting -> RR_EN=1: requester not last accepted; RR_EN=0: requester 0.
REQ-019 Accept = o_mem_en & i_mem_ready; o_gnt[winner]=1 that cycle only; last-accepted pointer updates to winner on accept.
REQ-020 Accepted write -> stay IDLE (next access may start the following cycle); accepted read -> RD_WAIT, owner register = winner.
REQ-021 Not accepted (i_mem_ready=0) -> HOLD, winner latched; HOLD keeps o_mem_en=1 and latched winner's fields regardless of other requester until accept.
REQ-022 HOLD accept -> same transitions as REQ-020.
REQ-023 Requesters SHALL hold i_req and fields stable until o_gnt; arbiter behaviour for a requester dropping i_req in HOLD is unspecified.
REQ-024 RD_WAIT: o_mem_en=0, o_gnt=0; on i_mem_rvalid -> o_rvalid[owner]=1, o_rd_data=i_mem_rd_data same cycle, next state IDLE.
REQ-025 At most one outstanding read; no new request is issued in the cycle i_mem_rvalid is seen.
REQ-026 i_mem_rvalid outside RD_WAIT SHALL be ignored (o_rvalid stays 0).
REQ-027 o_rd_data SHALL be 0 whenever o_rvalid==0; o_mem_* fields SHALL be 0 whenever o_mem_en==0.
REQ-028 No transfer data is modified; alignment and sign extension remain the responsibility of the downstream memory interface.

Reset
REQ-029 i_rst=1 at a clock edge -> state IDLE, last-accepted pointer = 1 (requester 0 wins first tie), owner = 0.
REQ-030 During reset, all outputs SHALL be 0; reset in HOLD or RD_WAIT abandons the access, and a subsequent stale i_mem_rvalid is ignored.

Verification
REQ-031 Req0 read addr 0x100, ready=1 -> o_gnt=01, o_mem_addr=0x100 same cycle; i_mem_rvalid with data 0xDEADBEEF 3 cycles later -> o_rvalid=01, o_rd_data=0xDEADBEEF.
REQ-032 RR_EN=1, both requesters write continuously, ready=1 -> grants alternate 01,10,01,10 after reset.
REQ-033 RR_EN=0, both requesters write continuously -> o_gnt=01 every cycle, requester 1 never granted.
REQ-034 Req1 write, ready=0 for 4 cycles, req0 asserted in cycle 2 -> o_mem_addr stays req1's address, o_gnt=10 when ready rises.
REQ-035 Read outstanding, i_rst pulsed, then i_mem_rvalid=1 -> o_rvalid=00, state IDLE.
REQ-036 i_mem_rvalid=1 while IDLE with no outstanding read -> o_rvalid=00, o_rd_data=0.

Source files
------------

// File: rtl/riscv_dmem_arbiter.sv
// Two-requester data-memory arbiter: one memory port, at most one outstanding read.
// A stalled request is latched and held until memory accepts it.
module riscv_dmem_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter bit          RR_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req,
    input  logic [2*XLEN-1:0]     i_addr,
    input  logic [1:0]            i_wr_en,
    input  logic [2*XLEN-1:0]     i_wr_data,
    input  logic [2*XLEN/8-1:0]   i_byte_sel,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_rvalid,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_mem_en,
    output logic [XLEN-1:0]       o_mem_addr,
    output logic                  o_mem_wr_en,
    output logic [XLEN-1:0]       o_mem_wr_data,
    output logic [XLEN/8-1:0]     o_mem_byte_sel,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [XLEN-1:0]       i_mem_rd_data
);

    localparam int unsigned BW = XLEN / 8;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRdWait
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   hold_q, hold_d;
    logic   owner_q, owner_d;

    logic            winner;
    logic            active;
    logic            accept;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            sel_wr;
    logic [BW-1:0]   sel_be;

    // In HOLD the latched winner keeps the port; otherwise arbitrate fresh.
    always_comb begin
        if (state_q == StHold) begin
            winner = hold_q;
        end else if (i_req == 2'b11) begin
            winner = RR_EN ? ~last_q : 1'b0;
        end else begin
            winner = i_req[1] & ~i_req[0];
        end
    end

    assign sel_addr  = winner ? i_addr[2*XLEN-1:XLEN]    : i_addr[XLEN-1:0];
    assign sel_wdata = winner ? i_wr_data[2*XLEN-1:XLEN] : i_wr_data[XLEN-1:0];
    assign sel_wr    = winner ? i_wr_en[1]               : i_wr_en[0];
    assign sel_be    = winner ? i_byte_sel[2*BW-1:BW]    : i_byte_sel[BW-1:0];

    assign active = ~i_rst & ((state_q == StHold) | ((state_q == StIdle) & (|i_req)));
    assign accept = active & i_mem_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (active) begin
                    hold_d = winner;
                    if (i_mem_ready) begin
                        last_d = winner;
                        if (sel_wr) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StRdWait;
                            owner_d = winner;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StRdWait: begin
                if (i_mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All outputs are forced to zero while reset is asserted.
    always_comb begin
        o_gnt          = 2'b00;
        o_rvalid       = 2'b00;
        o_rd_data      = '0;
        o_mem_en       = 1'b0;
        o_mem_addr     = '0;
        o_mem_wr_en    = 1'b0;
        o_mem_wr_data  = '0;
        o_mem_byte_sel = '0;
        if (active) begin
            o_mem_en       = 1'b1;
            o_mem_addr     = sel_addr;
            o_mem_wr_en    = sel_wr;
            o_mem_wr_data  = sel_wdata;
            o_mem_byte_sel = sel_be;
        end
        if (accept) begin
            o_gnt = winner ? 2'b10 : 2'b01;
        end
        if (~i_rst && (state_q == StRdWait) && i_mem_rvalid) begin
            o_rvalid  = owner_q ? 2'b10 : 2'b01;
            o_rd_data = i_mem_rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            hold_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Scoreboard bench: drives a round-robin and a fixed-priority arbiter side by side,
// predicting each cycle's outputs from a transaction-level model.
module tb_riscv_dmem_arbiter;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rd_data;
        logic        mem_en;
        logic [31:0] addr;
        logic        wr_en;
        logic [31:0] wr_data;
        logic [3:0]  be;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        rvalid_in;
    logic [31:0] rdata_in;

    logic [1:0]  req   [2];
    logic [63:0] addr  [2];
    logic [1:0]  wr    [2];
    logic [63:0] wdata [2];
    logic [7:0]  be    [2];
    logic [1:0]  gnt   [2];
    logic [1:0]  rv    [2];
    logic [31:0] rd    [2];
    logic        men   [2];
    logic [31:0] maddr [2];
    logic        mwr   [2];
    logic [31:0] mwd   [2];
    logic [3:0]  mbe   [2];

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(.XLEN(32), .RR_EN(1'b1)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_addr(addr[0]), .i_wr_en(wr[0]),
        .i_wr_data(wdata[0]), .i_byte_sel(be[0]), .o_gnt(gnt[0]), .o_rvalid(rv[0]),
        .o_rd_data(rd[0]), .o_mem_en(men[0]), .o_mem_addr(maddr[0]), .o_mem_wr_en(mwr[0]),
        .o_mem_wr_data(mwd[0]), .o_mem_byte_sel(mbe[0]), .i_mem_ready(ready),
        .i_mem_rvalid(rvalid_in), .i_mem_rd_data(rdata_in)
    );

    riscv_dmem_arbiter #(.XLEN(32), .RR_EN(1'b0)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_addr(addr[1]), .i_wr_en(wr[1]),
        .i_wr_data(wdata[1]), .i_byte_sel(be[1]), .o_gnt(gnt[1]), .o_rvalid(rv[1]),
        .o_rd_data(rd[1]), .o_mem_en(men[1]), .o_mem_addr(maddr[1]), .o_mem_wr_en(mwr[1]),
        .o_mem_wr_data(mwd[1]), .o_mem_byte_sel(mbe[1]), .i_mem_ready(ready),
        .i_mem_rvalid(rvalid_in), .i_mem_rd_data(rdata_in)
    );

    // Reference model state, per instance: -1 means "none".
    int   held   [2];
    int   rd_own [2];
    int   last   [2];
    bit   pend   [2][2];
    txn_t cur    [2][2];

    obs_t q_rr[$];
    obs_t q_fp[$];

    int vectors = 0;
    int miscompares = 0;

    int p_req0 = 0, p_req1 = 0, p_wr = 0, p_ready = 0, p_rv = 0, p_rst = 0;
    bit fix = 1'b0;

    task automatic step(input bit force_rst);
        obs_t e;
        int   c;
        int   p;
        @(posedge clk);
        #1;
        rst       = force_rst || ($urandom_range(999, 0) < p_rst);
        ready     = ($urandom_range(99, 0) < p_ready);
        rvalid_in = ($urandom_range(99, 0) < p_rv);
        rdata_in  = fix ? 32'hDEADBEEF : $urandom;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 2; n++) begin
                p = (n == 0) ? p_req0 : p_req1;
                if (!pend[k][n] && ($urandom_range(99, 0) < p)) begin
                    pend[k][n]     = 1'b1;
                    cur[k][n].wr   = ($urandom_range(99, 0) < p_wr);
                    cur[k][n].addr = fix ? 32'h100 * (n + 1) : $urandom;
                    cur[k][n].data = $urandom;
                    cur[k][n].be   = 4'($urandom);
                end
                req[k][n] = pend[k][n];
                if (pend[k][n]) begin
                    addr[k][n*32 +: 32]  = cur[k][n].addr;
                    wdata[k][n*32 +: 32] = cur[k][n].data;
                    wr[k][n]             = cur[k][n].wr;
                    be[k][n*4 +: 4]      = cur[k][n].be;
                end else begin
                    addr[k][n*32 +: 32]  = $urandom;
                    wdata[k][n*32 +: 32] = $urandom;
                    wr[k][n]             = 1'($urandom);
                    be[k][n*4 +: 4]      = 4'($urandom);
                end
            end

            e = '0;
            if (rst) begin
                held[k]   = -1;
                rd_own[k] = -1;
                last[k]   = 1;
            end else if (rd_own[k] >= 0) begin
                if (rvalid_in) begin
                    e.rvalid  = (rd_own[k] == 1) ? 2'b10 : 2'b01;
                    e.rd_data = rdata_in;
                    rd_own[k] = -1;
                end
            end else begin
                c = held[k];
                if (c < 0) begin
                    if (pend[k][0] && pend[k][1]) c = (k == 0) ? 1 - last[k] : 0;
                    else if (pend[k][0]) c = 0;
                    else if (pend[k][1]) c = 1;
                end
                if (c >= 0) begin
                    e.mem_en  = 1'b1;
                    e.addr    = cur[k][c].addr;
                    e.wr_en   = cur[k][c].wr;
                    e.wr_data = cur[k][c].data;
                    e.be      = cur[k][c].be;
                    if (ready) begin
                        e.gnt      = (c == 1) ? 2'b10 : 2'b01;
                        last[k]    = c;
                        held[k]    = -1;
                        pend[k][c] = 1'b0;
                        if (!cur[k][c].wr) rd_own[k] = c;
                    end else begin
                        held[k] = c;
                    end
                end
            end
            if (k == 0) q_rr.push_back(e);
            else q_fp.push_back(e);
            // Requesters abandon their pending access on reset.
            if (rst) begin
                pend[k][0] = 1'b0;
                pend[k][1] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        for (int k = 0; k < 2; k++) begin
            if ((k == 0 && q_rr.size() > 0) || (k == 1 && q_fp.size() > 0)) begin
                e = (k == 0) ? q_rr.pop_front() : q_fp.pop_front();
                a.gnt     = gnt[k];
                a.rvalid  = rv[k];
                a.rd_data = rd[k];
                a.mem_en  = men[k];
                a.addr    = maddr[k];
                a.wr_en   = mwr[k];
                a.wr_data = mwd[k];
                a.be      = mbe[k];
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s t=%0t got gnt=%b rv=%b rd=%h en=%b addr=%h we=%b wd=%h be=%h | exp gnt=%b rv=%b rd=%h en=%b addr=%h we=%b wd=%h be=%h",
                             (k == 0) ? "rr" : "fp", $time,
                             a.gnt, a.rvalid, a.rd_data, a.mem_en, a.addr, a.wr_en, a.wr_data, a.be,
                             e.gnt, e.rvalid, e.rd_data, e.mem_en, e.addr, e.wr_en, e.wr_data, e.be);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ready = 1'b0; rvalid_in = 1'b0; rdata_in = '0;
        for (int k = 0; k < 2; k++) begin
            req[k] = '0; addr[k] = '0; wr[k] = '0; wdata[k] = '0; be[k] = '0;
            held[k] = -1; rd_own[k] = -1; last[k] = 1;
            pend[k][0] = 1'b0; pend[k][1] = 1'b0;
        end
        step(1'b1);
        step(1'b1);

        // Requester 0 read at 0x100, response three cycles after the grant.
        fix = 1'b1; p_req0 = 100; p_req1 = 0; p_wr = 0; p_ready = 100; p_rv = 0;
        step(1'b0);
        p_req0 = 0;
        step(1'b0);
        step(1'b0);
        p_rv = 100;
        step(1'b0);
        p_rv = 0;
        step(1'b0);

        // Both requesters writing back to back: alternate vs. port 0 always.
        step(1'b1);
        p_req0 = 100; p_req1 = 100; p_wr = 100; p_ready = 100;
        repeat (12) step(1'b0);

        // Requester 1 stalls; requester 0 arrives mid-stall and must not steal the port.
        p_req0 = 0; p_req1 = 0;
        step(1'b1);
        p_req1 = 100; p_ready = 0;
        step(1'b0);
        p_req1 = 0; p_req0 = 100;
        repeat (3) step(1'b0);
        p_ready = 100;
        step(1'b0);
        p_req0 = 0;
        repeat (2) step(1'b0);

        // Reset while a read is outstanding, then a stale response in IDLE.
        step(1'b1);
        p_wr = 0; p_req0 = 100;
        step(1'b0);
        p_req0 = 0;
        step(1'b1);
        p_rv = 100;
        step(1'b0);
        step(1'b0);
        p_rv = 0;

        // Randomized traffic with occasional resets.
        fix = 1'b0;
        p_req0 = 60; p_req1 = 60; p_wr = 50; p_ready = 60; p_rv = 35; p_rst = 3;
        repeat (3000) step(1'b0);

        @(negedge clk);
        #1;
        if (q_rr.size() != 0 || q_fp.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, required 0",
                     q_rr.size(), q_fp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
